// File: rtl/ysyx_25040101_mem_arbiter.sv
// ysyx_25040101_mem_arbiter: round-robin IFU/LSU arbiter onto one memory port with response timeout
module ysyx_25040101_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid_i,
  output logic        ifu_req_ready_o,
  input  logic [31:0] ifu_addr_i,
  output logic        ifu_resp_valid_o,
  output logic [31:0] ifu_rdata_o,
  output logic        ifu_resp_err_o,
  input  logic        lsu_req_valid_i,
  output logic        lsu_req_ready_o,
  input  logic [31:0] lsu_addr_i,
  input  logic        lsu_wen_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [3:0]  lsu_wmask_i,
  output logic        lsu_resp_valid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_resp_err_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  input  logic        mem_resp_valid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_resp_err_i
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam bit TO_EN = TIMEOUT_CYCLES != 0;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  state_t state;
  logic last_owner, owner;
  logic [CNT_W-1:0] cnt;
  logic idle, done;
  logic [31:0] resp_rdata;
  logic resp_err;
  // owner/last_owner encoding: 0 = IFU, 1 = LSU; readys are forced low while reset is held
  assign idle = state == IDLE && !rst;
  assign ifu_req_ready_o = idle && ifu_req_valid_i && (!lsu_req_valid_i || last_owner);
  assign lsu_req_ready_o = idle && lsu_req_valid_i && (!ifu_req_valid_i || !last_owner);
  assign done = mem_resp_valid_i || (TO_EN && cnt == LIMIT);
  assign resp_rdata = mem_resp_valid_i ? mem_rdata_i : '0;
  assign resp_err = !mem_resp_valid_i || mem_resp_err_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last_owner <= 1'b1;
      owner <= 1'b0;
      cnt <= '0;
      mem_req_valid_o <= 1'b0;
      mem_addr_o <= '0;
      mem_wen_o <= 1'b0;
      mem_wdata_o <= '0;
      mem_wmask_o <= '0;
      ifu_resp_valid_o <= 1'b0;
      ifu_rdata_o <= '0;
      ifu_resp_err_o <= 1'b0;
      lsu_resp_valid_o <= 1'b0;
      lsu_rdata_o <= '0;
      lsu_resp_err_o <= 1'b0;
    end else begin
      ifu_resp_valid_o <= 1'b0;
      lsu_resp_valid_o <= 1'b0;
      case (state)
        IDLE: if (ifu_req_ready_o || lsu_req_ready_o) begin
          owner <= lsu_req_ready_o;
          last_owner <= lsu_req_ready_o;
          mem_addr_o <= lsu_req_ready_o ? lsu_addr_i : ifu_addr_i;
          mem_wen_o <= lsu_req_ready_o && lsu_wen_i;
          mem_wdata_o <= lsu_req_ready_o ? lsu_wdata_i : '0;
          mem_wmask_o <= (lsu_req_ready_o && lsu_wen_i) ? lsu_wmask_i : 4'h0;
          mem_req_valid_o <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: if (mem_req_ready_i) begin
          mem_req_valid_o <= 1'b0;
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: if (done) begin
          ifu_resp_valid_o <= !owner;
          lsu_resp_valid_o <= owner;
          if (owner) begin
            lsu_rdata_o <= resp_rdata;
            lsu_resp_err_o <= resp_err;
          end else begin
            ifu_rdata_o <= resp_rdata;
            ifu_resp_err_o <= resp_err;
          end
          state <= RESP;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_25040101_mem_arbiter.sv
// tb_ysyx_25040101_mem_arbiter: vector-table and corner-sequence checks for the memory arbiter
module tb_ysyx_25040101_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic ifu_req_valid_i = 0, ifu_req_ready_o, ifu_resp_valid_o, ifu_resp_err_o;
  logic [31:0] ifu_addr_i = 0, ifu_rdata_o;
  logic lsu_req_valid_i = 0, lsu_req_ready_o, lsu_wen_i = 0, lsu_resp_valid_o, lsu_resp_err_o;
  logic [31:0] lsu_addr_i = 0, lsu_wdata_i = 0, lsu_rdata_o;
  logic [3:0] lsu_wmask_i = 0, mem_wmask_o;
  logic mem_req_valid_o, mem_req_ready_i = 0, mem_wen_o, mem_resp_valid_i = 0, mem_resp_err_i = 0;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = 0;
  int total = 0, passed = 0;

  typedef struct {
    logic ifu_v; logic lsu_v;
    logic [31:0] ifu_addr; logic [31:0] lsu_addr;
    logic lsu_wen; logic [31:0] lsu_wdata; logic [3:0] lsu_wmask;
    int rdly; int wdly;
    logic [31:0] rdata; logic rerr;
    logic own;
  } vec_t;
  vec_t vecs[16];

  ysyx_25040101_mem_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o), .ifu_addr_i(ifu_addr_i),
    .ifu_resp_valid_o(ifu_resp_valid_o), .ifu_rdata_o(ifu_rdata_o), .ifu_resp_err_o(ifu_resp_err_o),
    .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o), .lsu_addr_i(lsu_addr_i),
    .lsu_wen_i(lsu_wen_i), .lsu_wdata_i(lsu_wdata_i), .lsu_wmask_i(lsu_wmask_i),
    .lsu_resp_valid_o(lsu_resp_valid_o), .lsu_rdata_o(lsu_rdata_o), .lsu_resp_err_o(lsu_resp_err_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_addr_o(mem_addr_o),
    .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_rdata_i(mem_rdata_i), .mem_resp_err_i(mem_resp_err_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic run(input vec_t v, input int k);
    string p;
    logic [31:0] ea, rd;
    logic ew, er;
    logic [3:0] em;
    p = $sformatf("v%0d", k);
    ea = v.own ? v.lsu_addr : v.ifu_addr;
    ew = v.own & v.lsu_wen;
    em = ew ? v.lsu_wmask : 4'h0;
    ifu_req_valid_i = v.ifu_v; lsu_req_valid_i = v.lsu_v;
    ifu_addr_i = v.ifu_addr; lsu_addr_i = v.lsu_addr;
    lsu_wen_i = v.lsu_wen; lsu_wdata_i = v.lsu_wdata; lsu_wmask_i = v.lsu_wmask;
    #1;
    chk({p, " ifu_ready"}, 32'(ifu_req_ready_o), 32'(!v.own));
    chk({p, " lsu_ready"}, 32'(lsu_req_ready_o), 32'(v.own));
    step();
    ifu_addr_i = ~ifu_addr_i; lsu_addr_i = ~lsu_addr_i;
    lsu_wen_i = ~lsu_wen_i; lsu_wdata_i = ~lsu_wdata_i; lsu_wmask_i = ~lsu_wmask_i;
    chk({p, " mem_valid"}, 32'(mem_req_valid_o), 32'd1);
    chk({p, " mem_addr"}, mem_addr_o, ea);
    chk({p, " mem_wen"}, 32'(mem_wen_o), 32'(ew));
    chk({p, " mem_wmask"}, 32'(mem_wmask_o), 32'(em));
    if (ew) chk({p, " mem_wdata"}, mem_wdata_o, v.lsu_wdata);
    repeat (v.rdly) step();
    if (v.rdly > 0) begin
      chk({p, " held_valid"}, 32'(mem_req_valid_o), 32'd1);
      chk({p, " held_addr"}, mem_addr_o, ea);
      chk({p, " held_mask"}, 32'(mem_wmask_o), 32'(em));
    end
    mem_req_ready_i = 1; step(); mem_req_ready_i = 0;
    chk({p, " wait_valid"}, 32'(mem_req_valid_o), 32'd0);
    repeat (v.wdly) step();
    mem_resp_valid_i = 1; mem_rdata_i = v.rdata; mem_resp_err_i = v.rerr;
    step();
    mem_resp_valid_i = 0; mem_rdata_i = 0; mem_resp_err_i = 0;
    chk({p, " ifu_resp"}, 32'(ifu_resp_valid_o), 32'(!v.own));
    chk({p, " lsu_resp"}, 32'(lsu_resp_valid_o), 32'(v.own));
    rd = v.own ? lsu_rdata_o : ifu_rdata_o;
    er = v.own ? lsu_resp_err_o : ifu_resp_err_o;
    chk({p, " rdata"}, rd, v.rdata);
    chk({p, " err"}, 32'(er), 32'(v.rerr));
    step();
    chk({p, " pulse_end"}, 32'({ifu_resp_valid_o, lsu_resp_valid_o}), 32'd0);
  endtask

  initial begin
    int n;
    vecs[0] = '{1, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 4'h0, 0, 0, 32'h0000_0413, 0, 0};
    vecs[1] = '{0, 1, 32'h0, 32'h8000_1004, 1, 32'hDEAD_BEEF, 4'hF, 3, 2, 32'h0, 0, 1};
    vecs[2] = '{0, 1, 32'h0, 32'h8000_2000, 0, 32'h1111_1111, 4'hF, 0, 1, 32'h1234_5678, 0, 1};
    vecs[3] = '{1, 0, 32'h8000_0004, 32'h0, 0, 32'h0, 4'h0, 1, 0, 32'hCAFE_F00D, 1, 0};
    for (int i = 0; i < 8; i++)
      vecs[4 + i] = '{1, 1, 32'h8000_0100 + 32'(i * 4), 32'h9000_0000 + 32'(i * 4), i[0],
                      32'hA5A5_0000 + 32'(i), 4'h3, 0, 0, 32'h5000_0000 + 32'(i), 0, i % 2 == 0};
    vecs[12] = '{0, 1, 32'h0, 32'h8000_3000, 0, 32'h0, 4'h1, 0, 0, 32'h7777_7777, 0, 1};
    vecs[13] = '{1, 1, 32'h8000_4000, 32'h8000_5000, 1, 32'h1, 4'h1, 0, 0, 32'h8888_8888, 0, 0};
    vecs[14] = '{1, 1, 32'h8000_4004, 32'h8000_5004, 1, 32'h2, 4'h2, 0, 0, 32'h9999_9999, 0, 1};
    vecs[15] = '{1, 0, 32'h8000_6000, 32'h0, 0, 32'h0, 4'h0, 2, 3, 32'h0BAD_F00D, 0, 0};
    #2;
    ifu_req_valid_i = 1; lsu_req_valid_i = 1;
    #1;
    chk("rst readys", 32'({ifu_req_ready_o, lsu_req_ready_o}), 32'd0);
    chk("rst mem_valid", 32'(mem_req_valid_o), 32'd0);
    chk("rst resp", 32'({ifu_resp_valid_o, lsu_resp_valid_o}), 32'd0);
    ifu_req_valid_i = 0; lsu_req_valid_i = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    for (int k = 0; k < 16; k++) run(vecs[k], k);
    ifu_req_valid_i = 0; lsu_req_valid_i = 0;
    // timeout: four silent WAIT cycles then an error pulse with zero data
    ifu_addr_i = 32'h8000_7000; ifu_req_valid_i = 1;
    step(); ifu_req_valid_i = 0;
    mem_req_ready_i = 1; step(); mem_req_ready_i = 0;
    n = 0;
    while (n < 20 && !ifu_resp_valid_o) begin step(); n++; end
    chk("to wait_cycles", 32'(n), 32'd4);
    chk("to err", 32'(ifu_resp_err_o), 32'd1);
    chk("to rdata", ifu_rdata_o, 32'h0);
    step();
    chk("to pulse_end", 32'(ifu_resp_valid_o), 32'd0);
    // response landing on the timeout cycle wins
    lsu_addr_i = 32'h8000_8000; lsu_wen_i = 0; lsu_req_valid_i = 1;
    step(); lsu_req_valid_i = 0;
    mem_req_ready_i = 1; step(); mem_req_ready_i = 0;
    repeat (3) step();
    mem_resp_valid_i = 1; mem_rdata_i = 32'hABCD_1234; mem_resp_err_i = 0;
    step(); mem_resp_valid_i = 0; mem_rdata_i = 0;
    chk("late lsu_resp", 32'(lsu_resp_valid_o), 32'd1);
    chk("late err", 32'(lsu_resp_err_o), 32'd0);
    chk("late rdata", lsu_rdata_o, 32'hABCD_1234);
    step();
    // async reset while waiting
    ifu_addr_i = 32'h8000_9000; ifu_req_valid_i = 1;
    step(); ifu_req_valid_i = 0;
    mem_req_ready_i = 1; step(); mem_req_ready_i = 0;
    step();
    #2;
    rst = 1; ifu_req_valid_i = 1; lsu_req_valid_i = 1;
    #1;
    chk("arst readys", 32'({ifu_req_ready_o, lsu_req_ready_o}), 32'd0);
    chk("arst mem_addr", mem_addr_o, 32'h0);
    chk("arst lsu_rdata", lsu_rdata_o, 32'h0);
    chk("arst mem_valid", 32'(mem_req_valid_o), 32'd0);
    ifu_req_valid_i = 0; lsu_req_valid_i = 0;
    step();
    rst = 0; mem_resp_valid_i = 1; mem_rdata_i = 32'h1357_9BDF;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      mem_resp_valid_i = 0;
      if (ifu_resp_valid_o || lsu_resp_valid_o) n++;
    end
    chk("arst no_resp", 32'(n), 32'd0);
    ifu_req_valid_i = 1; lsu_req_valid_i = 1;
    #1;
    chk("arst tie ifu", 32'(ifu_req_ready_o), 32'd1);
    chk("arst tie lsu", 32'(lsu_req_ready_o), 32'd0);
    ifu_req_valid_i = 0; lsu_req_valid_i = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
